// File: rtl/uart_rx_controller.sv
// UART receiver: 2-flop synchronised rx, centre-sampled start/data/parity/stop bits,
// one-cycle rx_valid strobe carrying parity and framing status.
module uart_rx_controller #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 perr_pend_q, perr_pend_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 rx_s;

  assign rx_s = sync2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      sh_q         <= '0;
      perr_pend_q  <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      sh_q         <= sh_d;
      perr_pend_q  <= perr_pend_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    sync1_d      = rx;
    sync2_d      = sync1_q;
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    idx_d        = idx_q;
    sh_d         = sh_q;
    perr_pend_d  = perr_pend_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        // A start bit that is high again at its centre was a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          sh_d  = {rx_s, sh_q[DATA_BITS-1:1]};
          idx_d = idx_q + 3'd1;
          if (idx_q == IDX_LAST) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d       = '0;
          perr_pend_d = ((^sh_q) ^ rx_s) != PARITY_ODD;
          state_d     = ST_STOP;
        end
      end
      ST_STOP: begin
        // Deliver even on error; a low stop bit parks in BREAK until the line recovers.
        if (cnt_q == BIT_LAST) begin
          cnt_d        = '0;
          rx_data_d    = sh_q;
          parity_err_d = perr_pend_q;
          frame_err_d  = ~rx_s;
          rx_valid_d   = 1'b1;
          state_d      = rx_s ? ST_IDLE : ST_BREAK;
        end
      end
      ST_BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
